// File: rtl/image_block_pkg.sv
// image_block_pkg: drain FSM state encoding and shared image-block defaults.
package image_block_pkg;

    typedef enum logic [1:0] {IDLE, CMD, XFER, RELEASE} drain_state_t;

    localparam int WORDS_PER_PKT_DEF = 5;
    localparam int ADDR_STEP_DEF     = 8;

endpackage

// File: rtl/drain_skid_fifo.sv
// drain_skid_fifo: 2-entry output FIFO between the buffer RAM read port and the DDR write stream.
module drain_skid_fifo #(
    parameter int WIDTH = 512
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             valid,
    output logic [1:0]       count
);

    logic [WIDTH-1:0] mem [2];
    logic             wr_ptr;
    logic             rd_ptr;

    assign dout  = mem[rd_ptr];
    assign valid = count != 2'd0;

    always_ff @(posedge clk) begin
        if (rst) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop)
                rd_ptr <= ~rd_ptr;
            count <= count + 2'(push) - 2'(pop);
        end
    end

endmodule

// File: rtl/result_buf_drain_ctrl.sv
// result_buf_drain_ctrl: drains complete packets from the result buffer RAM into DDR write bursts.
module result_buf_drain_ctrl
    import image_block_pkg::*;
#(
    parameter int WORDS_PER_PKT = WORDS_PER_PKT_DEF,
    parameter int FRAME_PKTS    = 360,
    parameter int DDR_ADDR_W    = 28,
    parameter int ADDR_STEP     = ADDR_STEP_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic [DDR_ADDR_W-1:0] base_addr,
    input  logic                  pkt_ready,
    output logic [4:0]            rd_addr,
    input  logic [511:0]          rd_data,
    output logic                  rd_row_data_done,
    output logic                  cmd_req,
    output logic [DDR_ADDR_W-1:0] cmd_addr,
    input  logic                  cmd_ack,
    output logic [511:0]          wdata,
    output logic                  wvalid,
    input  logic                  wready,
    output logic                  frame_done
);

    localparam int WC_W = $clog2(WORDS_PER_PKT + 1);
    localparam int PC_W = $clog2(FRAME_PKTS + 1);
    localparam logic [DDR_ADDR_W-1:0] PKT_STEP  = DDR_ADDR_W'(WORDS_PER_PKT * ADDR_STEP);
    localparam logic [WC_W-1:0]       NWORDS    = WC_W'(WORDS_PER_PKT);
    localparam logic [WC_W-1:0]       LAST_WORD = WC_W'(WORDS_PER_PKT - 1);
    localparam logic [PC_W-1:0]       LAST_PKT  = PC_W'(FRAME_PKTS - 1);

    drain_state_t          state, state_n;
    logic [WC_W-1:0]       issued, sent;
    logic                  in_flight;
    logic [1:0]            fifo_cnt;
    logic                  xfer, issue, start, last_xfer, frame_end;
    logic [DDR_ADDR_W-1:0] pkt_addr;
    logic [PC_W-1:0]       pkt_cnt;

    assign xfer = wvalid & wready;

    // A read is issued only if its word is guaranteed a FIFO slot on arrival, counting this cycle's pop.
    always_comb begin
        start            = state == IDLE && enable && pkt_ready;
        issue            = state == XFER && issued != NWORDS &&
                           ({1'b0, fifo_cnt} - 3'(xfer) + 3'(in_flight)) < 3'd2;
        last_xfer        = state == XFER && xfer && sent == LAST_WORD;
        frame_end        = state == RELEASE && pkt_cnt == LAST_PKT;
        rd_row_data_done = state == RELEASE;
        frame_done       = frame_end;
        state_n          = state == IDLE ? (start ? CMD : IDLE) :
                           state == CMD  ? (cmd_ack ? XFER : CMD) :
                           state == XFER ? (last_xfer ? RELEASE : XFER) : IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_n;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_addr   <= 5'd0;
            in_flight <= 1'b0;
            issued    <= '0;
            sent      <= '0;
            pkt_cnt   <= '0;
            pkt_addr  <= base_addr;
            cmd_req   <= 1'b0;
            cmd_addr  <= '0;
        end else begin
            in_flight <= issue;
            if (issue) begin
                rd_addr <= rd_addr + 5'd1;
                issued  <= issued + 1'b1;
            end
            if (xfer)
                sent <= sent + 1'b1;
            if (start) begin
                cmd_req  <= 1'b1;
                cmd_addr <= pkt_cnt == '0 ? base_addr : pkt_addr;
                issued   <= '0;
                sent     <= '0;
            end
            if (state == CMD && cmd_ack)
                cmd_req <= 1'b0;
            if (state == RELEASE) begin
                pkt_cnt  <= frame_end ? '0 : pkt_cnt + 1'b1;
                pkt_addr <= frame_end ? base_addr : cmd_addr + PKT_STEP;
            end
        end
    end

    drain_skid_fifo #(.WIDTH(512)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (in_flight),
        .din   (rd_data),
        .pop   (xfer),
        .dout  (wdata),
        .valid (wvalid),
        .count (fifo_cnt)
    );

endmodule

// File: tb/tb_result_buf_drain_ctrl.sv
// tb_result_buf_drain_ctrl: randomized bench for the drain controller against a packet-level reference model.
module tb_result_buf_drain_ctrl;

    localparam int W  = 5;
    localparam int AW = 28;

    logic clk = 0, rst = 1, enable = 0, pkt_ready = 0, cmd_ack = 0, wready = 0;
    logic [AW-1:0] base_addr = '0;
    logic [511:0]  ram [32];
    logic [511:0]  rd_data = '0, rd_data_b = '0;

    logic [4:0]    rd_addr, rd_addr_b;
    logic          rd_row_data_done, rd_row_data_done_b, cmd_req, cmd_req_b;
    logic [AW-1:0] cmd_addr, cmd_addr_b;
    logic [511:0]  wdata, wdata_b;
    logic          wvalid, wvalid_b, frame_done, frame_done_b;

    int cmp_n = 0, fail_n = 0, pkt_idx = 0;

    // Short frame instance for frame-end behaviour; default instance for long address runs.
    result_buf_drain_ctrl #(.FRAME_PKTS(3)) dut (
        .clk(clk), .rst(rst), .enable(enable), .base_addr(base_addr), .pkt_ready(pkt_ready),
        .rd_addr(rd_addr), .rd_data(rd_data), .rd_row_data_done(rd_row_data_done),
        .cmd_req(cmd_req), .cmd_addr(cmd_addr), .cmd_ack(cmd_ack), .wdata(wdata),
        .wvalid(wvalid), .wready(wready), .frame_done(frame_done)
    );

    result_buf_drain_ctrl dut_b (
        .clk(clk), .rst(rst), .enable(enable), .base_addr(base_addr), .pkt_ready(pkt_ready),
        .rd_addr(rd_addr_b), .rd_data(rd_data_b), .rd_row_data_done(rd_row_data_done_b),
        .cmd_req(cmd_req_b), .cmd_addr(cmd_addr_b), .cmd_ack(cmd_ack), .wdata(wdata_b),
        .wvalid(wvalid_b), .wready(wready), .frame_done(frame_done_b)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        rd_data   <= ram[rd_addr];
        rd_data_b <= ram[rd_addr_b];
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [AW-1:0] exp_addr(input int frame);
        return base_addr + AW'((pkt_idx % frame) * W * 8);
    endfunction

    task automatic run_packet(input int ack_dly, input int mode, input int drop_en_at, input int rst_at);
        int t, n, k, first_v, last_v, pulses;
        logic stalled;
        logic [511:0] held, expw;
        pkt_ready = 1;
        wready = 0;
        t = 0;
        while (!cmd_req && t < 50) begin
            step();
            t++;
        end
        cmp_n++;
        if (cmd_req !== 1'b1) begin
            fail_n++;
            $display("FAIL cmd_req_wait: cmd_req=%b required 1", cmd_req);
            return;
        end
        for (int i = 0; i <= ack_dly; i++) begin
            cmp_n++;
            if (cmd_req !== 1'b1 || cmd_addr !== exp_addr(3) || cmd_addr_b !== exp_addr(360)) begin
                fail_n++;
                $display("FAIL cmd_addr pkt %0d: req=%b addr=%h/%h required 1 %h/%h", pkt_idx,
                         cmd_req, cmd_addr, cmd_addr_b, exp_addr(3), exp_addr(360));
            end
            if (i < ack_dly)
                step();
        end
        cmd_ack = 1;
        step();
        cmd_ack = 0;
        cmp_n++;
        if (cmd_req !== 1'b0) begin
            fail_n++;
            $display("FAIL cmd_req_drop: cmd_req=%b required 0", cmd_req);
        end
        n = 0; k = 0; first_v = -1; last_v = 0; stalled = 0; held = '0;
        while (n < W && k < 100) begin
            if (rst_at == n) begin
                rst = 1;
                wready = 0;
                step();
                cmp_n++;
                if ({cmd_req, wvalid, rd_row_data_done, frame_done} !== 4'b0 || cmd_addr !== '0 ||
                    wdata !== '0 || rd_addr !== 5'd0) begin
                    fail_n++;
                    $display("FAIL reset_mid: req=%b valid=%b done=%b fd=%b addr=%h rd_addr=%0d wdata_nz=%b required all 0",
                             cmd_req, wvalid, rd_row_data_done, frame_done, cmd_addr, rd_addr, wdata != '0);
                end
                rst = 0;
                pkt_ready = 0;
                pkt_idx = 0;
                pulses = 0;
                for (int i = 0; i < 8; i++) begin
                    step();
                    pulses += int'(rd_row_data_done);
                end
                cmp_n++;
                if (pulses != 0 || rd_addr !== 5'd0) begin
                    fail_n++;
                    $display("FAIL reset_no_release: pulses=%0d rd_addr=%0d required 0 0", pulses, rd_addr);
                end
                return;
            end
            if (drop_en_at == n)
                enable = 0;
            wready = mode == 0 ? 1'b1 : mode == 1 ? (k % 3 == 0) : 1'($urandom_range(0, 1));
            if (stalled) begin
                cmp_n++;
                if (wvalid !== 1'b1 || wdata !== held) begin
                    fail_n++;
                    $display("FAIL stall_hold pkt %0d word %0d: wvalid=%b data_changed=%b required 1 0",
                             pkt_idx, n, wvalid, wdata !== held);
                end
            end
            if (wvalid && first_v < 0)
                first_v = k;
            if (wvalid && wready) begin
                expw = ram[(pkt_idx * W + n) % 32];
                cmp_n++;
                if (wdata !== expw || rd_row_data_done !== 1'b0) begin
                    fail_n++;
                    $display("FAIL word pkt %0d idx %0d: got tag %0d done=%b required tag %0d done 0",
                             pkt_idx, n, wdata[7:0], rd_row_data_done, expw[7:0]);
                end
                n++;
                last_v = k;
            end
            stalled = wvalid && !wready;
            held = wdata;
            step();
            k++;
        end
        wready = 0;
        cmp_n++;
        if (n != W) begin
            fail_n++;
            $display("FAIL xfer_timeout pkt %0d: words=%0d required %0d", pkt_idx, n, W);
            return;
        end
        if (mode == 0) begin
            cmp_n++;
            if (last_v - first_v != W - 1) begin
                fail_n++;
                $display("FAIL throughput pkt %0d: span=%0d required %0d", pkt_idx, last_v - first_v, W - 1);
            end
        end
        cmp_n++;
        if (rd_row_data_done !== 1'b1 || rd_row_data_done_b !== 1'b1 ||
            frame_done !== (pkt_idx % 3 == 2) || frame_done_b !== (pkt_idx % 360 == 359)) begin
            fail_n++;
            $display("FAIL release pkt %0d: done=%b/%b fd=%b/%b required 1/1 %b/%b", pkt_idx,
                     rd_row_data_done, rd_row_data_done_b, frame_done, frame_done_b,
                     pkt_idx % 3 == 2, pkt_idx % 360 == 359);
        end
        pkt_idx++;
        step();
        cmp_n++;
        if (rd_row_data_done !== 1'b0 || frame_done !== 1'b0 || cmd_req !== 1'b0) begin
            fail_n++;
            $display("FAIL post_release: done=%b fd=%b req=%b required 0 0 0",
                     rd_row_data_done, frame_done, cmd_req);
        end
    endtask

    task automatic test_reset();
        rst = 1;
        step();
        step();
        cmp_n++;
        if ({cmd_req, wvalid, rd_row_data_done, frame_done} !== 4'b0 || cmd_addr !== '0 ||
            wdata !== '0 || rd_addr !== 5'd0) begin
            fail_n++;
            $display("FAIL reset_outputs: req=%b valid=%b done=%b fd=%b addr=%h rd_addr=%0d required all 0",
                     cmd_req, wvalid, rd_row_data_done, frame_done, cmd_addr, rd_addr);
        end
        rst = 0;
        step();
        cmp_n++;
        if (cmd_req !== 1'b0 || wvalid !== 1'b0) begin
            fail_n++;
            $display("FAIL idle_no_ready: req=%b valid=%b required 0 0", cmd_req, wvalid);
        end
        pkt_idx = 0;
    endtask

    task automatic test_single_packet();
        enable = 1;
        run_packet(3, 0, -1, -1);
    endtask

    task automatic test_backpressure();
        run_packet(1, 1, -1, -1);
    endtask

    task automatic test_wrap_and_frame();
        rst = 1;
        step();
        rst = 0;
        pkt_idx = 0;
        for (int p = 0; p < 7; p++)
            run_packet(int'($urandom_range(0, 3)), p == 6 ? 0 : int'($urandom_range(0, 2)), -1, -1);
    endtask

    task automatic test_enable();
        int raised;
        run_packet(2, 2, 2, -1);
        pkt_ready = 1;
        raised = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            raised += int'(cmd_req);
        end
        cmp_n++;
        if (raised != 0) begin
            fail_n++;
            $display("FAIL enable_block: cmd_req cycles=%0d required 0", raised);
        end
        enable = 1;
        run_packet(0, 0, -1, -1);
    endtask

    task automatic test_reset_mid();
        run_packet(1, 0, -1, 2);
        base_addr = AW'($urandom) & ~AW'(63);
        enable = 1;
        run_packet(0, 2, -1, -1);
    endtask

    task automatic test_random();
        for (int p = 0; p < 5; p++)
            run_packet(int'($urandom_range(0, 4)), 2, -1, -1);
    endtask

    initial begin
        logic [511:0] w;
        for (int i = 0; i < 32; i++) begin
            for (int j = 0; j < 16; j++)
                w[j*32 +: 32] = $urandom;
            w[7:0] = 8'(i);
            ram[i] = w;
        end
        base_addr = AW'($urandom) & ~AW'(63);
        test_reset();
        test_single_packet();
        test_backpressure();
        test_wrap_and_frame();
        test_enable();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_n, fail_n);
        $finish;
    end

endmodule

// File: doc/result_buf_drain_ctrl.md
RESULT_BUF_DRAIN_CTRL -- requirements
Module: result_buf_drain_ctrl

Interface
REQ-001 SHALL have parameter WORDS_PER_PKT, default 5, giving the 512-bit words per packet (two image rows).
REQ-002 SHALL have parameter FRAME_PKTS, default 360, giving the packets per frame.
REQ-003 SHALL have parameter DDR_ADDR_W, default 28, giving the DDR address width.
REQ-004 SHALL have parameter ADDR_STEP, default 8, giving the DDR address increment per 512-bit word.
REQ-005 SHALL have port clk, input, 1, the single clock for all logic.
REQ-006 SHALL have port rst, input, 1, the reset; synchronous, active-high.
REQ-007 SHALL have port enable, input, 1, which allows new packet starts while high.
REQ-008 SHALL have port base_addr, input, DDR_ADDR_W, the frame start address, sampled in IDLE.
REQ-009 SHALL have port pkt_ready, input, 1, high when the buffer holds at least one complete packet.
REQ-010 SHALL have port rd_addr, output, 5, the buffer RAM read address.
REQ-011 SHALL have port rd_data, input, 512, the buffer RAM read data, valid one cycle after rd_addr.
REQ-012 SHALL have port rd_row_data_done, output, 1, a one-cycle pulse that releases one packet.
REQ-013 SHALL have port cmd_req, input/output as follows: output, 1, the DDR write burst request.
REQ-014 SHALL have port cmd_addr, output, DDR_ADDR_W, the burst start address, stable while cmd_req is high.
REQ-015 SHALL have port cmd_ack, input, 1, the burst request acceptance.
REQ-016 SHALL have port wdata, output, 512, the write data.
REQ-017 SHALL have port wvalid, output, 1, high when wdata is valid.
REQ-018 SHALL have port wready, input, 1, the write data acceptance.
REQ-019 SHALL have port frame_done, output, 1, a one-cycle pulse after the last packet of a frame.

Function
REQ-020 SHALL implement the states IDLE, CMD, XFER, RELEASE.
REQ-021 SHALL move IDLE->CMD when enable and pkt_ready are both high, loading the packet address.
REQ-022 SHALL hold cmd_req high in CMD until cmd_ack is seen, then go to XFER; cmd_req, cmd_addr and the packet address are registered outputs.
REQ-023 SHALL, in XFER, issue exactly WORDS_PER_PKT RAM reads, incrementing rd_addr by one per read and wrapping mod 32 (31->0), with no reset of rd_addr between packets.
REQ-024 SHALL capture each read word into a 2-entry output FIFO one cycle after issue.
REQ-025 SHALL issue a read only when FIFO occupancy plus reads in flight is less than 2, so data is never lost under backpressure.
REQ-026 SHALL present the FIFO head on wdata/wvalid; a word transfers on wvalid and wready both high.
REQ-027 SHALL sustain one word per cycle when wready is held high.
REQ-028 SHALL move XFER->RELEASE when the WORDS_PER_PKT-th word transfers, then pulse rd_row_data_done for exactly one cycle and return to IDLE.
REQ-029 SHALL assert rd_row_data_done only after all words of the packet have left the FIFO.
REQ-030 SHALL advance the packet address by WORDS_PER_PKT*ADDR_STEP per packet, truncated to DDR_ADDR_W bits.
REQ-031 SHALL count packets; on packet FRAME_PKTS it SHALL pulse frame_done together with rd_row_data_done, reload the address from base_addr and clear the count.
REQ-032 SHALL use enable low only to block new IDLE->CMD transitions; a packet in progress SHALL always complete.
REQ-033 SHALL keep wvalid held with wdata stable while wready is low; wvalid SHALL NOT drop without a transfer.
REQ-034 SHALL NOT start a new packet in the cycle of the rd_row_data_done pulse; the next packet starts no earlier than the IDLE cycle that follows.

Reset
REQ-035 SHALL, on rst high at a clock edge, go to state IDLE with rd_addr=0, an empty FIFO, packet count 0 and the packet address loaded from base_addr.
REQ-036 SHALL drive cmd_req=0, cmd_addr=0, wvalid=0, wdata=0, rd_row_data_done=0 and frame_done=0 during and after reset.
REQ-037 SHALL, on reset mid-packet, discard the partial packet and issue no rd_row_data_done.

Structure
REQ-038 SHALL place the state encoding and the WORDS_PER_PKT and ADDR_STEP defaults in a shared package (image_block_pkg), used with result_buf.
REQ-039 SHALL implement the 2-entry output FIFO as sub-module drain_skid_fifo, parameterised by width, with synchronous reset.

Verification
REQ-040 SHALL cover a single packet: pkt_ready=1, cmd_ack after 3 cycles, wready=1 -> 5 words from rd_addr 0..4, one rd_row_data_done pulse, cmd_addr=base_addr.
REQ-041 SHALL cover backpressure: wready toggling 1,0,0,1,... -> exactly 5 transfers in RAM order, no duplicates, and wdata stable while stalled.
REQ-042 SHALL cover wrap-around: 7 back-to-back packets -> rd_addr sequence 30,31,0,1,2 in packet 7, and cmd_addr=base+6*40.
REQ-043 SHALL cover frame end: FRAME_PKTS=3 -> frame_done coincides with the 3rd rd_row_data_done, and the 4th cmd_addr=base_addr.
REQ-044 SHALL cover enable: enable low mid-packet -> the packet completes; with pkt_ready high afterwards, no cmd_req is raised until enable returns high.
REQ-045 SHALL cover reset: rst asserted after 2 words -> all outputs 0 the next cycle, no rd_row_data_done, and rd_addr=0.
